// File: rtl/md4_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : md4_pkg
//  Description : Shared MD4 constants, round-2 step tables and FSM state type
//                used by the iterative MD4 round stages.
//  Revision    : 1.0 - initial release
// ============================================================================
package md4_pkg;

    // Round-2 additive constant (sqrt(2) * 2^30)
    localparam logic [31:0] C_K2    = 32'h5A827999;
    // Steps per round; the step counter width assumes exactly 16
    localparam int          C_STEPS = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } md4_state_t;

    // Left-rotate amount for round-2 step i: {3,5,9,13}[i%4]
    function automatic logic [3:0] md4_r2_shift(input logic [3:0] step);
        logic [3:0] s;
        case (step[1:0])
            2'd0:    s = 4'd3;
            2'd1:    s = 4'd5;
            2'd2:    s = 4'd9;
            default: s = 4'd13;
        endcase
        return s;
    endfunction

    // Message word index for round-2 step i: 4*(i%4) + i/4
    function automatic logic [3:0] md4_r2_word(input logic [3:0] step);
        return {step[1:0], step[3:2]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/md4_g_step.sv
`default_nettype none
// ============================================================================
//  Module      : md4_g_step
//  Description : One MD4 round-2 step datapath (combinational):
//                n = rotl32(a + G(b,c,d) + xk + K2, s), G = bitwise majority.
//  Revision    : 1.0 - initial release
// ============================================================================
module md4_g_step
    import md4_pkg::*;
#(
    parameter logic [31:0] K2 = C_K2
) (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] c,
    input  logic [31:0] d,
    input  logic [31:0] xk,
    input  logic [3:0]  s,
    output logic [31:0] n
);

    logic [31:0] w_g;
    logic [31:0] w_t;

    // Majority function, then the wrapping four-term sum
    assign w_g = (b & c) | (b & d) | (c & d);
    assign w_t = a + w_g + xk + K2;

    // Rotate left; s is always within 3..13 so the right shift never reaches 32
    assign n = (w_t << s) | (w_t >> (6'd32 - {2'b00, s}));

endmodule
`default_nettype wire

// File: rtl/md4_stage2_iter.sv
`default_nettype none
// ============================================================================
//  Module      : md4_stage2_iter
//  Description : Iterative MD4 round-2 engine. Accepts chaining words and a
//                512-bit block from round 1, runs the 16 round-2 steps at one
//                step per clock, then holds the result for round 3.
//  Revision    : 1.0 - initial release
// ============================================================================
module md4_stage2_iter
    import md4_pkg::*;
#(
    parameter logic [31:0] K2 = C_K2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [31:0]  a,
    input  logic [31:0]  b,
    input  logic [31:0]  c,
    input  logic [31:0]  d,
    input  logic [511:0] x,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [31:0]  out_a,
    output logic [31:0]  out_b,
    output logic [31:0]  out_c,
    output logic [31:0]  out_d,
    output logic         busy
);

    localparam logic [3:0] c_last_step = 4'(C_STEPS - 1);

    md4_state_t   r_state;
    md4_state_t   w_state_nxt;
    logic [3:0]   r_step;
    logic [31:0]  r_a;
    logic [31:0]  r_b;
    logic [31:0]  r_c;
    logic [31:0]  r_d;
    logic [511:0] r_x;

    logic [3:0]   w_k;
    logic [3:0]   w_s;
    logic [31:0]  w_xk;
    logic [31:0]  w_n;

    assign w_k  = md4_r2_word(r_step);
    assign w_s  = md4_r2_shift(r_step);
    assign w_xk = r_x[{w_k, 5'b00000} +: 32];

    md4_g_step #(
        .K2 (K2)
    ) u_g_step (
        .a  (r_a),
        .b  (r_b),
        .c  (r_c),
        .d  (r_d),
        .xk (w_xk),
        .s  (w_s),
        .n  (w_n)
    );

    // State register, step counter and working registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_step  <= 4'd0;
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_c     <= 32'd0;
            r_d     <= 32'd0;
            r_x     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_a    <= a;
                        r_b    <= b;
                        r_c    <= c;
                        r_d    <= d;
                        r_x    <= x;
                        r_step <= 4'd0;
                    end
                end
                ST_RUN: begin
                    // Rotate roles so the next step always updates r_a
                    r_a    <= r_d;
                    r_b    <= w_n;
                    r_c    <= r_b;
                    r_d    <= r_c;
                    r_step <= r_step + 4'd1;
                end
                default: ;
            endcase
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                busy = 1'b1;
                if (r_step == c_last_step) w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Result is only exposed while it is valid; zero otherwise
    assign out_a = out_valid ? r_a : 32'd0;
    assign out_b = out_valid ? r_b : 32'd0;
    assign out_c = out_valid ? r_c : 32'd0;
    assign out_d = out_valid ? r_d : 32'd0;

endmodule
`default_nettype wire

// File: tb/tb_md4_stage2_iter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_md4_stage2_iter
//  Description : Scoreboard bench for md4_stage2_iter against a behavioural
//                MD4 round-2 reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_md4_stage2_iter;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [31:0]  a = 32'd0, b = 32'd0, c = 32'd0, d = 32'd0;
    logic [511:0] x = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [31:0]  out_a, out_b, out_c, out_d;
    logic         busy;

    logic [31:0]  ga = 32'd0, gb = 32'd0, gc = 32'd0, gd = 32'd0, gx = 32'd0;
    logic [3:0]   gs = 4'd3;
    logic [31:0]  gn;

    typedef struct {
        logic [127:0] res;
        longint       acc;
    } exp_t;

    exp_t   q[$];
    longint cyc = 0;
    int     n_checks = 0;
    int     n_fail = 0;
    int     n_pushed = 0;
    int     n_results = 0;
    bit     prev_valid = 1'b0;
    bit     rand_ready = 1'b0;

    int s_tab[4]  = '{3, 5, 9, 13};
    int k_tab[16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};

    md4_stage2_iter dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c         (c),
        .d         (d),
        .x         (x),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_a     (out_a),
        .out_b     (out_b),
        .out_c     (out_c),
        .out_d     (out_d),
        .busy      (busy)
    );

    md4_g_step u_g (
        .a  (ga),
        .b  (gb),
        .c  (gc),
        .d  (gd),
        .xk (gx),
        .s  (gs),
        .n  (gn)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] rotl(input logic [31:0] v, input int s);
        return (v << s) | (v >> (32 - s));
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] p, q1, r);
        logic [31:0] m;
        for (int i = 0; i < 32; i++) m[i] = (p[i] + q1[i] + r[i]) >= 2;
        return m;
    endfunction

    // Textbook MD4 round 2: steps cycle the target through A, D, C, B
    function automatic logic [127:0] model(input logic [31:0] ia, ib, ic, id,
                                           input logic [511:0] ix);
        logic [31:0] v[4];
        logic [31:0] w[16];
        v[0] = ia; v[1] = ib; v[2] = ic; v[3] = id;
        for (int k = 0; k < 16; k++) w[k] = ix[32*k +: 32];
        for (int i = 0; i < 16; i++) begin
            int j;
            j = (4 - (i % 4)) % 4;
            v[j] = rotl(v[j] + maj(v[(j+1)%4], v[(j+2)%4], v[(j+3)%4])
                        + w[k_tab[i]] + 32'h5A827999, s_tab[i % 4]);
        end
        return {v[0], v[1], v[2], v[3]};
    endfunction

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] r;
        for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
        return r;
    endfunction

    // Monitor: compare every presented result with the scoreboard head
    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got %h expected none",
                         {out_a, out_b, out_c, out_d});
            end else begin
                if (!prev_valid) check("latency", 128'(cyc - q[0].acc), 128'd16);
                check("result", {out_a, out_b, out_c, out_d}, q[0].res);
                if (out_ready) begin
                    void'(q.pop_front());
                    n_results++;
                end
            end
        end
        prev_valid = out_valid;
    end

    // Random backpressure during the soak phase
    always begin
        @(posedge clk);
        #1;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    end

    // Drive one block; call at posedge+1. Returns at posedge+1 after accept.
    task automatic send(input logic [31:0] ia, ib, ic, id, input logic [511:0] ix);
        int guard;
        guard = 0;
        in_valid = 1'b1;
        a = ia; b = ib; c = ic; d = id; x = ix;
        do begin
            @(negedge clk);
            guard++;
        end while (!in_ready && guard < 1000);
        if (!in_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL accept_timeout: got in_ready=0 expected 1");
        end else begin
            q.push_back('{res: model(ia, ib, ic, id, ix), acc: cyc + 1});
            n_pushed++;
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while ((q.size() != 0 || out_valid) && guard < 2000) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
    endtask

    initial begin
        logic [511:0] blk;
        int guard;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset_state", {95'd0, in_ready, out_valid, busy, out_a, out_b, out_c, out_d},
              {95'd0, 1'b1, 1'b0, 1'b0, 128'd0});

        // Step datapath: zero inputs, then random values vs reference
        ga = 0; gb = 0; gc = 0; gd = 0; gx = 0; gs = 4'd3;
        #1;
        check("g_step_zero", 128'(gn), 128'(32'hD413CCCA));
        for (int i = 0; i < 6; i++) begin
            ga = $urandom; gb = $urandom; gc = $urandom; gd = $urandom; gx = $urandom;
            gs = 4'(s_tab[i % 4]);
            #1;
            check("g_step_rand", 128'(gn),
                  128'(rotl(ga + maj(gb, gc, gd) + gx + 32'h5A827999, s_tab[i % 4])));
        end

        // Standard IV with a zero block
        @(posedge clk);
        #1;
        send(32'h67452301, 32'hefcdab89, 32'h98badcfe, 32'h10325476, '0);
        drain();

        // Stall in DONE for 10 cycles, then release
        out_ready = 1'b0;
        send($urandom, $urandom, $urandom, $urandom, rand_block());
        guard = 0;
        while (!out_valid && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("stall_hold", {126'd0, in_ready, out_valid}, {126'd0, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("release_idle", {126'd0, in_ready, out_valid}, {126'd0, 1'b1, 1'b0});

        // New data offered mid-run must be ignored
        @(posedge clk);
        #1;
        send($urandom, $urandom, $urandom, $urandom, rand_block());
        repeat (7) @(posedge clk);
        #1;
        in_valid = 1'b1;
        a = $urandom; b = $urandom; c = $urandom; d = $urandom; x = rand_block();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("run_ignores_input", {126'd0, in_ready, busy}, {126'd0, 1'b0, 1'b1});
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain();

        // Reset pulse at step 9 aborts the block
        send($urandom, $urandom, $urandom, $urandom, rand_block());
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        q.delete();
        n_pushed--;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("abort_state", {95'd0, in_ready, out_valid, busy, out_a, out_b, out_c, out_d},
              {95'd0, 1'b1, 1'b0, 1'b0, 128'd0});
        @(posedge clk);
        #1;
        send($urandom, $urandom, $urandom, $urandom, rand_block());
        drain();

        // Random soak with backpressure
        rand_ready = 1'b1;
        for (int n = 0; n < 200; n++) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            blk = rand_block();
            send($urandom, $urandom, $urandom, $urandom, blk);
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        drain();
        check("result_count", 128'(n_results), 128'(n_pushed));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
